// File: rtl/nibble_add_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibble_add_seq_if : request/result bus and adder4 operand bus for the       |
// |                     nibble-serial add/subtract sequencer                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface nibble_add_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // Request side
  logic         start;
  logic         sub;
  logic         cin_in;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  // Result side
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout_out;

  // External adder4 operands and its combinational answer
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  // Environment side: issues requests and hosts the adder4
  modport master (
    output start, sub, cin_in, op_a, op_b, add_sum, add_cout,
    input  busy, done, result, cout_out, add_a, add_b, add_cin
  );

  // Sequencer side
  modport slave (
    input  start, sub, cin_in, op_a, op_b, add_sum, add_cout,
    output busy, done, result, cout_out, add_a, add_b, add_cin
  );
endinterface

`default_nettype wire

// File: rtl/nibble_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibble_add_seq : wide add/subtract performed one nibble per clock through   |
// |                  an external 4-bit adder; result published on completion    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  nibble_add_seq_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_result;
  logic            r_sub;
  logic            r_carry;
  logic            r_cout;
  logic [IW-1:0]   r_idx;

  logic            w_accept;
  logic            w_last;
  logic [W-1:0]    w_acc_next;

  // A request is taken whenever the sequencer is not mid-operation, so DONE can chain
  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_idx == C_LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.add_a    = 4'h0;
    bus.add_b    = 4'h0;
    bus.add_cin  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy    = 1'b1;
        // Operands are shift registers, so the live nibble is always bits [3:0]
        bus.add_a   = r_a[3:0];
        bus.add_b   = r_sub ? ~r_b[3:0] : r_b[3:0];
        bus.add_cin = r_carry;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_state_next = w_accept ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{r_idx, 2'b00} +: 4] = bus.add_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_idx    <= '0;
    end else if (w_accept) begin
      r_a     <= bus.op_a;
      r_b     <= bus.op_b;
      r_acc   <= '0;
      r_sub   <= bus.sub;
      r_carry <= bus.sub ? 1'b1 : bus.cin_in;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_acc   <= w_acc_next;
      r_carry <= bus.add_cout;
      r_idx   <= r_idx + 1'b1;
      // Publish only the complete word so result never shows a half-built value
      if (w_last) begin
        r_result <= w_acc_next;
        r_cout   <= bus.add_cout;
      end
    end
  end

  assign bus.result   = r_result;
  assign bus.cout_out = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nibble_add_seq : directed and random checks of nibble_add_seq (NIBBLES=4)|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_nibble_add_seq;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  nibble_add_seq_if #(.NIBBLES(N)) bus ();

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // adder4 stand-in
  assign {bus.add_cout, bus.add_sum} = bus.add_a + bus.add_b + {3'b000, bus.add_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [16:0] ref_total(input logic [15:0] a, input logic [15:0] b,
                                            input logic s, input logic c);
    logic [16:0] t;
    if (s) t = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else   t = {1'b0, a} + {1'b0, b} + {16'd0, c};
    return t;
  endfunction

  // Behavioural model: phase 0 idle, 1..N run cycle number, N+1 done cycle
  int          m_ph;
  logic [15:0] m_a, m_bx;
  logic        m_c0;
  logic [16:0] m_tot;
  logic [15:0] m_res;
  logic        m_cout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_a <= '0; m_bx <= '0; m_c0 <= 1'b0;
      m_tot <= '0; m_res <= '0; m_cout <= 1'b0;
    end else if ((m_ph == 0 || m_ph == N + 1) && bus.start) begin
      m_ph  <= 1;
      m_a   <= bus.op_a;
      m_bx  <= bus.sub ? ~bus.op_b : bus.op_b;
      m_c0  <= bus.sub ? 1'b1 : bus.cin_in;
      m_tot <= ref_total(bus.op_a, bus.op_b, bus.sub, bus.cin_in);
    end else if (m_ph >= 1 && m_ph < N) begin
      m_ph <= m_ph + 1;
    end else if (m_ph == N) begin
      m_ph   <= N + 1;
      m_res  <= m_tot[15:0];
      m_cout <= m_tot[16];
    end else begin
      m_ph <= 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] lo, mask, cin_e, a_e, b_e;
    logic run;
    run = (m_ph >= 1 && m_ph <= N);
    lo  = 4 * (m_ph - 1);
    if (run) begin
      mask  = (32'd1 << lo) - 32'd1;
      cin_e = (m_ph == 1) ? {31'd0, m_c0}
            : ((({16'd0, m_a} & mask) + ({16'd0, m_bx} & mask) + {31'd0, m_c0}) >> lo) & 32'd1;
      a_e   = ({16'd0, m_a} >> lo) & 32'hF;
      b_e   = ({16'd0, m_bx} >> lo) & 32'hF;
    end else begin
      cin_e = 0; a_e = 0; b_e = 0;
    end
    chk("cyc_busy",    {31'd0, bus.busy},     {31'd0, run});
    chk("cyc_done",    {31'd0, bus.done},     {31'd0, (m_ph == N + 1)});
    chk("cyc_result",  {16'd0, bus.result},   {16'd0, m_res});
    chk("cyc_cout",    {31'd0, bus.cout_out}, {31'd0, m_cout});
    chk("cyc_add_a",   {28'd0, bus.add_a},    a_e);
    chk("cyc_add_b",   {28'd0, bus.add_b},    b_e);
    chk("cyc_add_cin", {31'd0, bus.add_cin},  cin_e);
  end

  // Issue one operation, scramble inputs after accept, wait for done and check literals
  task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic c, input logic [15:0] er,
                       input logic ec, input bit ripple);
    int n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.sub = s; bus.cin_in = c;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);
    bus.sub = ~s; bus.cin_in = ~c;
    n = 1;
    while (!bus.done && n < 20) begin
      if (ripple && n >= 2 && n <= 4) chk({nm, "_ripple_cin"}, {31'd0, bus.add_cin}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, 32'd5);
    chk({nm, "_result"}, {16'd0, bus.result}, {16'd0, er});
    chk({nm, "_cout"}, {31'd0, bus.cout_out}, {31'd0, ec});
  endtask

  initial begin
    logic [16:0] t;
    logic [15:0] ra, rb;
    logic rs, rc;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin_in = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_add_a", {28'd0, bus.add_a}, 32'd0);
    rst_n = 1'b1;

    do_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("add2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("add3", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub2", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

    // start during RUN ignored, then held into DONE for a back-to-back second op
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.sub = 1'b0; bus.cin_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = 16'hAAAA; bus.op_b = 16'h0101;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_first_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_first_result", {16'd0, bus.result}, 32'h3333);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_second_busy", {31'd0, bus.busy}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_second_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_second_result", {16'd0, bus.result}, 32'hABAB);
    chk("b2b_second_cout", {31'd0, bus.cout_out}, 32'd0);

    // reset in RUN cycle 3
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_a = 16'h1234; bus.op_b = 16'h1111; bus.sub = 1'b0; bus.cin_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_result", {16'd0, bus.result}, 32'd0);
    chk("midrst_add_cin", {31'd0, bus.add_cin}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst_no_done", {31'd0, bus.done}, 32'd0);
    end
    do_op("restart", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      t  = ref_total(ra, rb, rs, rc);
      do_op("rand", ra, rb, rs, rc, t[15:0], t[16], 1'b0);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
